// File: rtl/data_memory_resp.sv
// Fixed-latency word memory: one request at a time, acknowledged LATENCY cycles after accept.
// Optional macro DMEM_RANGE_CHECK_EN adds err_o and blocks out-of-range accesses instead of wrapping.
module data_memory_resp #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        ack_o,
    output logic [31:0] data_o,
`ifdef DMEM_RANGE_CHECK_EN
    output logic        err_o,
`endif
    output logic        busy_o
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic             r_ack;
    logic             r_busy;
    logic [31:0]      r_rdata;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_mem [DEPTH];

    logic             w_fire;
    logic [IDX_W-1:0] w_idx;
    logic             w_oob;
    logic             w_unused;

    // w_fire marks the final WAIT cycle, where the memory access takes place
    assign w_fire = (r_state == WAIT) && (r_cnt == 8'd0);
    assign w_idx  = r_addr[IDX_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    logic r_err;
    assign w_oob    = (r_addr >> (IDX_W + 2)) != 32'd0;
    assign err_o    = r_err;
    assign w_unused = ^r_addr[1:0];
`else
    assign w_oob    = 1'b0;
    assign w_unused = ^{r_addr[31:IDX_W+2], r_addr[1:0]};
`endif

    // Request capture and memory array carry no reset; the array survives reset
    always_ff @(posedge clk_i) begin
        if (r_state == IDLE && req_i) begin
            r_we    <= write_i;
            r_addr  <= addr_i;
            r_wdata <= data_i;
        end
        if (w_fire && r_we && !w_oob) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= 32'd0;
`ifdef DMEM_RANGE_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_state <= WAIT;
                        r_cnt   <= CNT_INIT;
                        r_busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
                        r_err   <= w_oob;
`endif
                        if (!r_we) begin
                            r_rdata <= w_oob ? 32'd0 : r_mem[w_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o  = r_ack;
    assign busy_o = r_busy;
    assign data_o = r_rdata;

endmodule

// File: tb/tb_data_memory_resp.sv
// Scoreboard bench for data_memory_resp: LATENCY=10 instance for function/latency/reset,
// LATENCY=1 instance for back-to-back throughput.
module tb_data_memory_resp;

    localparam int LAT0 = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;

    logic        req0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = '0, din0 = '0;
    logic        ack0, busy0, err0;
    logic [31:0] dout0;

    logic        req1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = '0, din1 = '0;
    logic        ack1, busy1;
    logic [31:0] dout1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] d;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_resp #(.LATENCY(LAT0), .DEPTH(512)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req0), .write_i(wr0),
        .addr_i(addr0), .data_i(din0), .ack_o(ack0), .data_o(dout0),
`ifdef DMEM_RANGE_CHECK_EN
        .err_o(err0),
`endif
        .busy_o(busy0)
    );

`ifdef DMEM_RANGE_CHECK_EN
    logic err1;
`else
    assign err0 = 1'b0;
`endif

    data_memory_resp #(.LATENCY(1), .DEPTH(512)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req1), .write_i(wr1),
        .addr_i(addr1), .data_i(din1), .ack_o(ack1), .data_o(dout1),
`ifdef DMEM_RANGE_CHECK_EN
        .err_o(err1),
`endif
        .busy_o(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack from the LATENCY=10 instance must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && ack0) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(ack0), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_data", dout0, e.d);
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
`ifdef DMEM_RANGE_CHECK_EN
                chk("ack_err", 32'(err0), 32'(e.err));
`endif
            end
        end
    end

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_err, input logic scramble);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        req0 = 1'b1; wr0 = we; addr0 = a; din0 = d;
        sb.push_back('{d: exp_d, err: exp_err, cyc: cyc + 1 + LAT0});
        if (scramble) begin
            @(posedge clk); #1;
            addr0 = 32'hFFFF_FFFF;
            din0  = 32'hFFFF_FFFF;
        end
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (ack0) begin
                got = 1'b1;
                break;
            end
        end
        req0 = 1'b0;
        chk("ack_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        int acks;
        // Reset state, applied from time zero
        #2;
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_data0", dout0, 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        txn(1'b1, 32'h14, 32'h1234, 32'hDEAD_BEEF, 1'b0, 1'b0);
        txn(1'b0, 32'h14, 32'h0, 32'h1234, 1'b0, 1'b0);
        txn(1'b1, 32'h18, 32'h0BAD_F00D, 32'h1234, 1'b0, 1'b1);
        txn(1'b0, 32'h18, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);

        txn(1'b1, 32'h004, 32'h0000_AAAA, 32'h0BAD_F00D, 1'b0, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
        txn(1'b1, 32'h804, 32'h55, 32'h0BAD_F00D, 1'b1, 1'b0);
        txn(1'b0, 32'h004, 32'h0, 32'h0000_AAAA, 1'b0, 1'b0);
        txn(1'b0, 32'h804, 32'h0, 32'h0, 1'b1, 1'b0);
        txn(1'b1, 32'h20, 32'h1111_2222, 32'h0, 1'b0, 1'b0);
`else
        txn(1'b1, 32'h804, 32'h55, 32'h0BAD_F00D, 1'b0, 1'b0);
        txn(1'b0, 32'h004, 32'h0, 32'h55, 1'b0, 1'b0);
        txn(1'b0, 32'h804, 32'h0, 32'h55, 1'b0, 1'b0);
        txn(1'b1, 32'h20, 32'h1111_2222, 32'h55, 1'b0, 1'b0);
`endif

        // Abort a write mid-WAIT with reset; outputs must clear at once
        @(posedge clk); #1;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h20; din0 = 32'hCAFE_F00D;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ack", 32'(ack0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_data", dout0, 32'd0);
        req0 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack0) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 32'h1111_2222, 1'b0, 1'b0);

        // LATENCY=1 with req held: ack every third cycle, busy low only in accept cycles
        @(posedge clk); #1;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0; din1 = 32'h77;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("b2b_ack", 32'(ack1), ((j % 3) == 2) ? 32'd1 : 32'd0);
            chk("b2b_busy", 32'(busy1), ((j % 3) != 0) ? 32'd1 : 32'd0);
        end
        req1 = 1'b0;

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
